// File: rtl/sm2_pkg.sv
// sm2_pkg: shared SM2 constants and handshake state encoding
package sm2_pkg;
    localparam int OPW = 256;
    localparam logic [OPW-1:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
    typedef enum logic [1:0] {IDLE, PROC, FIN} state_t;
endpackage

// File: rtl/mul256_seq_if.sv
// mul256_seq_if: operand/result bundle with start/done/busy handshake
interface mul256_seq_if;
    import sm2_pkg::*;
    logic [OPW-1:0]   a;
    logic [OPW-1:0]   b;
    logic             start;
    logic [2*OPW-1:0] product;
    logic             done;
    logic             busy;
    modport master (output a, b, start, input product, done, busy);
    modport slave  (input a, b, start, output product, done, busy);
endinterface

// File: rtl/mul_row_256xw.sv
// mul_row_256xw: combinational acc_hi + a*digit row, kept apart for later pipelining or DSP mapping
module mul_row_256xw
    import sm2_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic [OPW-1:0]      a,
    input  logic [WORD-1:0]     digit,
    input  logic [OPW-1:0]      acc_hi,
    output logic [OPW+WORD-1:0] sum
);
    assign sum = (OPW+WORD)'(acc_hi) + (OPW+WORD)'(a) * (OPW+WORD)'(digit);
endmodule

// File: rtl/mul256_seq.sv
// mul256_seq: word-serial 256x256 unsigned multiplier, one WORD-bit digit of b per cycle
module mul256_seq
    import sm2_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic        clk,
    input  logic        rst,
    mul256_seq_if.slave bus
);
    localparam int NITER = OPW / WORD;
    localparam int CW = $clog2(NITER);
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OPW-1:0]     a_q, a_d, b_q, b_d;
    logic [2*OPW-1:0]   acc_q, acc_d, prod_q, prod_d, acc_nx;
    logic [OPW+WORD-1:0] sum;

    mul_row_256xw #(.WORD(WORD)) u_row (
        .a      (a_q),
        .digit  (b_q[WORD-1:0]),
        .acc_hi (acc_q[2*OPW-1:OPW]),
        .sum    (sum)
    );

    always_comb begin
        assert ($bits(sum) == OPW + WORD);
        acc_nx  = (2*OPW)'({sum, acc_q[OPW-1:0]} >> WORD);
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = PROC;
                a_d     = bus.a;
                b_d     = bus.b;
                acc_d   = '0;
                cnt_d   = '0;
            end
            PROC: begin
                acc_d = acc_nx;
                b_d   = b_q >> WORD;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NITER - 1)) begin
                    state_d = FIN;
                    prod_d  = acc_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.product = prod_q;
    assign bus.done    = (state_q == FIN);
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mul256_seq.sv
// tb_mul256_seq: directed self-checking bench for mul256_seq (WORD=32)
module tb_mul256_seq;
    import sm2_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul256_seq_if bus();
    mul256_seq #(.WORD(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input logic [255:0] x, input logic [255:0] y,
                          output int lat, output int bsy, output int dcyc);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = ~x;
        bus.b = ~y;
        lat = 0;
        bsy = 0;
        dcyc = -1;
        for (int n = 0; n < 20; n++) begin
            if (bus.busy) bsy++;
            if (bus.done) begin
                lat = n;
                dcyc = cyc;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [255:0] fa(int i);
        return {8{32'h9E3779B9}} + 256'(i);
    endfunction

    function automatic logic [255:0] fb(int i);
        return {8{32'h7F4A7C15}} ^ 256'(i * 8);
    endfunction

    logic [255:0] va [5];
    logic [255:0] vb [5];
    logic [511:0] ve [5];
    logic [511:0] e;
    int lat, bsy, d1, d2, ndone;

    initial begin
        bus.a = '0;
        bus.b = '0;
        bus.start = 1'b0;
        tick();
        tick();
        chk("rst_product", bus.product, '0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;

        run_op('0, {8{32'h12345678}}, lat, bsy, d1);
        chk("zero_lat", lat, 8);
        chk("zero_busy", bsy, 9);
        chk("zero_product", bus.product, '0);
        tick();
        chk("zero_idle_busy", bus.busy, 0);
        chk("zero_idle_done", bus.done, 0);

        run_op(256'd1, P, lat, bsy, d1);
        chk("one_p", bus.product, {256'h0, P});
        tick();
        run_op(P, 256'd1, lat, bsy, d2);
        chk("p_one", bus.product, {256'h0, P});
        chk("b2b_spacing", d2 - d1, 10);
        tick();

        va[0] = '1;                  vb[0] = '1;
        ve[0] = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
        va[1] = '0; va[1][255] = 1'b1; vb[1] = va[1];
        ve[1] = '0; ve[1][510] = 1'b1;
        va[2] = '1;                  vb[2] = 256'd2;
        ve[2] = {255'h0, 1'b1, {255{1'b1}}, 1'b0};
        va[3] = 256'hFFFFFFFF;       vb[3] = 256'hFFFFFFFF;
        ve[3] = 512'hFFFFFFFE00000001;
        va[4] = '0; va[4][128] = 1'b1; vb[4] = va[4] + 256'd1;
        ve[4] = '0; ve[4][256] = 1'b1; ve[4][128] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_op(va[k], vb[k], lat, bsy, d1);
            chk($sformatf("vec%0d", k), bus.product, ve[k]);
            tick();
        end

        for (int i = 0; i < 30; i++) begin
            bus.a = fa(i);
            bus.b = fb(i);
            bus.start = 1'b1;
            tick();
            chk($sformatf("hold_done%0d", i), bus.done, (i % 10 == 8) ? 1 : 0);
            if (i % 10 == 8) begin
                e = 512'(fa(i - 8)) * 512'(fb(i - 8));
                chk($sformatf("hold_prod%0d", i), bus.product, e);
            end
        end
        bus.start = 1'b0;
        tick();

        bus.a = {8{32'hDEADBEEF}};
        bus.b = {8{32'h01020304}};
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_done", bus.done, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_product", bus.product, '0);
        run_op(va[4], vb[4], lat, bsy, d1);
        chk("after_abort_lat", lat, 8);
        chk("after_abort_prod", bus.product, ve[4]);
        tick();

        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = '1;
        bus.b = '1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", bus.busy, 0);
        chk("rst_start_product", bus.product, '0);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.done || bus.busy) ndone++;
        end
        chk("rst_start_quiet", ndone, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul256_seq.md
Name: mul256_seq

Overview:
- Word-serial 256x256-bit unsigned multiplier; the producer of the 512-bit operand consumed by the SM2 fast Fp reduction block (mod256_p).
- Uses the same start/done handshake style as the reducer.
- Scans operand b one WORD-bit digit per cycle against the full 256-bit operand a.
- Accumulates with a shift-right carry-save-free adder; presents the full 512-bit product with a one-cycle done pulse.

Parameters:
- WORD, 32: digit width of b processed per cycle. Legal values: 16, 32, 64 (must divide 256).
- NITER, 256/WORD: derived iteration count. Localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  256  multiplicand; sampled only when start is accepted.
- b  input  256  multiplier; sampled only when start is accepted.
- start  input  1  request; accepted only in IDLE.
- product  output  512  a*b, registered; valid from done onward, held until the next completion.
- done  output  1  single-cycle pulse when product is updated.
- busy  output  1  high in PROC and FIN.

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high. All state changes on the rising clk edge.
- Reset (rst=1 at an edge):
  - state=IDLE, counter=0; a_reg, b_reg, acc cleared.
  - product=0, done=0, busy=0.
  - rst has priority over every other input.
- States:
  - IDLE -> PROC when start=1. On that edge: a_reg<=a, b_reg<=b, acc<=0, counter<=0.
  - PROC: stays NITER cycles. counter increments each cycle; PROC -> FIN on the edge where counter==NITER-1.
  - FIN -> IDLE unconditionally. On the edge entering FIN, product<=final acc.
- PROC datapath, one step per cycle:
  - digit = b_reg[WORD-1:0].
  - sum[256+WORD-1:0] = acc[511:256] + a_reg*digit. No overflow is possible; assert sum width is exactly 256+WORD.
  - acc <= {sum, acc[255:0]} >> WORD.
  - b_reg <= b_reg >> WORD.
  - After NITER steps, acc == a*b exactly (no modular reduction in this block).
- Outputs:
  - done = (state==FIN): exactly one cycle, registered-state decode.
  - busy = (state!=IDLE).
- Latency: start sampled at edge k -> done high during cycle after edge k+NITER (NITER+1 cycles). With WORD=32: 9 cycles.
- Throughput: a new start may be accepted in the IDLE cycle right after FIN, so minimum start-to-start spacing is NITER+2 cycles.
- start while busy: ignored. No queuing, no effect on the running operation.
- a/b changing while busy: no effect; only the latched copies are used.
- product is stable between done pulses; it is not cleared at start.
- Reset mid-operation: abort, return to IDLE, product=0, no done pulse.
- Simultaneous rst and start: reset wins, start dropped.

Decomposition:
- Shared package sm2_pkg holds:
  - SM2 prime constant P (256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF).
  - Operand width constant (256).
  - State encoding IDLE/PROC/FIN, shared with the reducer.
- One natural sub-module, mul_row_256xw: combinational 256xWORD multiply-accumulate, computing acc_hi + a*digit. It isolates the critical path for later pipelining or DSP mapping.

Test Plan:
- a=0, b=arbitrary (0x1234...): done after 9 cycles (WORD=32); product=0; busy high for exactly 9 cycles.
- a=1, b=P: product={256'h0, P}. Then a=P, b=1 back-to-back, start in the IDLE cycle after FIN: product={256'h0, P}, second done exactly 10 cycles after the first.
- a=b=2^256-1: product = 256'hFFFF...FFFE (63 F's then E) concatenated with 256'h0000...0001.
- start held high continuously with a,b toggling every cycle: only operands present at IDLE acceptance are used; done period is 10 cycles; results match a golden model.
- rst asserted at PROC counter=4: no done, product=0, busy=0 next cycle. A new start immediately after completes correctly.
- Chain test, WORD=16 and WORD=64 builds, 1000 random pairs: product feeds mod256_p and the final result matches (a*b) mod P.
